// File: rtl/stdp_pkg.sv
// Shared types and arithmetic helpers for the STDP synapse array.
// Contents:
//   weight_t / time_t : weight and spike-timer types at the default widths
//   stdp_dw           : base-2 STDP step, zero once the shift reaches the weight width
//   stdp_sat_add      : add clamped to an upper bound (wide intermediate, no wrap)
//   stdp_sat_sub      : subtract clamped to a lower bound (no underflow)
//   stdp_clamp        : clamp a value into [lo, hi]
package stdp_pkg;

    localparam int unsigned W_WIDTH_DEF = 16;
    localparam int unsigned T_WIDTH_DEF = 8;

    typedef logic [W_WIDTH_DEF-1:0] weight_t;
    typedef logic [T_WIDTH_DEF-1:0] time_t;

    // Step scaled by 2^-(delta_t >> tau_shift); a shift that would clear the
    // whole weight range is reported as no change at all.
    function automatic logic [31:0] stdp_dw(input logic [31:0] step,
                                            input logic [31:0] delta_t,
                                            input logic [31:0] tau_shift,
                                            input logic [31:0] w_width);
        logic [31:0] sh;
        sh = delta_t >> tau_shift;
        if (sh >= w_width) begin
            return 32'd0;
        end else begin
            return step >> sh;
        end
    endfunction

    function automatic logic [31:0] stdp_sat_add(input logic [31:0] w,
                                                 input logic [31:0] dw,
                                                 input logic [31:0] w_max);
        logic [32:0] sum;
        sum = {1'b0, w} + {1'b0, dw};
        if (sum > {1'b0, w_max}) begin
            return w_max;
        end else begin
            return sum[31:0];
        end
    endfunction

    function automatic logic [31:0] stdp_sat_sub(input logic [31:0] w,
                                                 input logic [31:0] dw,
                                                 input logic [31:0] w_min);
        if (dw > w) begin
            return w_min;
        end else if ((w - dw) < w_min) begin
            return w_min;
        end else begin
            return w - dw;
        end
    endfunction

    function automatic logic [31:0] stdp_clamp(input logic [31:0] v,
                                               input logic [31:0] lo,
                                               input logic [31:0] hi);
        if (v < lo) begin
            return lo;
        end else if (v > hi) begin
            return hi;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/stdp_synapse_cell.sv
// One plastic synapse: weight register, presynaptic timer/valid flag,
// LTP/LTD evaluation with clamping, and the host write override.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   learn_en        : enables STDP weight changes (timer runs regardless)
//   pre_spike       : this synapse's presynaptic spike
//   post_spike      : shared postsynaptic spike
//   post_valid      : shared post timer holds a real spike time
//   post_time       : shared post timer value
//   wr_sel          : host write targets this synapse this cycle
//   wr_data         : host write value (clamped)
//   weight          : registered weight
//   upd             : one-cycle pulse when STDP changed the weight
module stdp_synapse_cell
    import stdp_pkg::*;
#(
    parameter int unsigned W_WIDTH   = 16,
    parameter int unsigned T_WIDTH   = 8,
    parameter int unsigned A_PLUS    = 32,
    parameter int unsigned A_MINUS   = 32,
    parameter int unsigned TAU_SHIFT = 2,
    parameter int unsigned WINDOW    = 255,
    parameter int unsigned W_INIT    = 100,
    parameter int unsigned W_MIN     = 0,
    parameter int unsigned W_MAX     = 65535
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               learn_en,
    input  logic               pre_spike,
    input  logic               post_spike,
    input  logic               post_valid,
    input  logic [T_WIDTH-1:0] post_time,
    input  logic               wr_sel,
    input  logic [W_WIDTH-1:0] wr_data,
    output logic [W_WIDTH-1:0] weight,
    output logic               upd
);

    localparam logic [T_WIDTH-1:0] T_MAX = {T_WIDTH{1'b1}};
    localparam logic [T_WIDTH-1:0] T_ONE = {{(T_WIDTH-1){1'b0}}, 1'b1};

    logic [W_WIDTH-1:0] weight_r;
    logic [T_WIDTH-1:0] pre_time_r;
    logic               pre_valid_r;
    logic               upd_r;
    logic               ltp_s;
    logic               ltd_s;
    logic [31:0]        cand_s;
    logic [W_WIDTH-1:0] weight_next_s;
    logic               upd_next_s;

    // STDP candidate weight and write override; a simultaneous pre/post pair
    // satisfies neither the LTP nor the LTD condition and leaves the weight.
    always_comb begin
        ltp_s = learn_en & post_spike & ~pre_spike & pre_valid_r
              & (32'(pre_time_r) < WINDOW);
        ltd_s = learn_en & pre_spike & ~post_spike & post_valid
              & (32'(post_time) < WINDOW);
        cand_s = 32'(weight_r);
        if (ltp_s) begin
            cand_s = stdp_sat_add(32'(weight_r),
                                  stdp_dw(A_PLUS, 32'(pre_time_r), TAU_SHIFT, W_WIDTH),
                                  W_MAX);
        end else if (ltd_s) begin
            cand_s = stdp_sat_sub(32'(weight_r),
                                  stdp_dw(A_MINUS, 32'(post_time), TAU_SHIFT, W_WIDTH),
                                  W_MIN);
        end else begin
            cand_s = 32'(weight_r);
        end
        weight_next_s = weight_r;
        upd_next_s    = 1'b0;
        if (wr_sel) begin
            weight_next_s = W_WIDTH'(stdp_clamp(32'(wr_data), W_MIN, W_MAX));
            upd_next_s    = 1'b0;
        end else begin
            weight_next_s = W_WIDTH'(cand_s);
            upd_next_s    = (W_WIDTH'(cand_s) != weight_r);
        end
    end

    // Weight, update pulse and saturating presynaptic timer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            weight_r    <= W_WIDTH'(W_INIT);
            pre_time_r  <= {T_WIDTH{1'b0}};
            pre_valid_r <= 1'b0;
            upd_r       <= 1'b0;
        end else begin
            weight_r <= weight_next_s;
            upd_r    <= upd_next_s;
            if (pre_spike) begin
                pre_time_r  <= {T_WIDTH{1'b0}};
                pre_valid_r <= 1'b1;
            end else if (pre_valid_r && (pre_time_r != T_MAX)) begin
                pre_time_r <= pre_time_r + T_ONE;
            end else begin
                pre_time_r <= pre_time_r;
            end
        end
    end

    assign weight = weight_r;
    assign upd    = upd_r;

endmodule

// File: rtl/stdp_synapse_array.sv
// N_SYN plastic synapses sharing one postsynaptic neuron, pair-based base-2
// STDP. Owns the shared post timer; each cell owns its pre timer and weight.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   learn_en    : STDP enable (timers run regardless)
//   pre_spike   : per-synapse presynaptic spikes
//   post_spike  : postsynaptic spike
//   wr_en/wr_idx/wr_data : host weight write (out-of-range index ignored)
//   weight      : flattened weights, synapse i at [i*W_WIDTH +: W_WIDTH]
//   upd         : per-synapse pulse when STDP changed the weight
module stdp_synapse_array
    import stdp_pkg::*;
#(
    parameter int unsigned N_SYN     = 8,
    parameter int unsigned W_WIDTH   = 16,
    parameter int unsigned T_WIDTH   = 8,
    parameter int unsigned A_PLUS    = 32,
    parameter int unsigned A_MINUS   = 32,
    parameter int unsigned TAU_SHIFT = 2,
    parameter int unsigned WINDOW    = 255,
    parameter int unsigned W_INIT    = 100,
    parameter int unsigned W_MIN     = 0,
    parameter int unsigned W_MAX     = 65535,
    localparam int unsigned IDX_W    = (N_SYN > 1) ? $clog2(N_SYN) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       learn_en,
    input  logic [N_SYN-1:0]           pre_spike,
    input  logic                       post_spike,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [W_WIDTH-1:0]         wr_data,
    output logic [N_SYN*W_WIDTH-1:0]   weight,
    output logic [N_SYN-1:0]           upd
);

    localparam logic [T_WIDTH-1:0] T_MAX = {T_WIDTH{1'b1}};
    localparam logic [T_WIDTH-1:0] T_ONE = {{(T_WIDTH-1){1'b0}}, 1'b1};

    logic [T_WIDTH-1:0] post_time_r;
    logic               post_valid_r;

    // Shared saturating postsynaptic timer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            post_time_r  <= {T_WIDTH{1'b0}};
            post_valid_r <= 1'b0;
        end else if (post_spike) begin
            post_time_r  <= {T_WIDTH{1'b0}};
            post_valid_r <= 1'b1;
        end else if (post_valid_r && (post_time_r != T_MAX)) begin
            post_time_r <= post_time_r + T_ONE;
        end else begin
            post_time_r <= post_time_r;
        end
    end

    for (genvar i = 0; i < N_SYN; i++) begin : g_cell
        logic wr_sel_s;
        assign wr_sel_s = wr_en && (32'(wr_idx) == 32'(i)) && (32'(wr_idx) < N_SYN);

        stdp_synapse_cell #(
            .W_WIDTH  (W_WIDTH),
            .T_WIDTH  (T_WIDTH),
            .A_PLUS   (A_PLUS),
            .A_MINUS  (A_MINUS),
            .TAU_SHIFT(TAU_SHIFT),
            .WINDOW   (WINDOW),
            .W_INIT   (W_INIT),
            .W_MIN    (W_MIN),
            .W_MAX    (W_MAX)
        ) u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .learn_en  (learn_en),
            .pre_spike (pre_spike[i]),
            .post_spike(post_spike),
            .post_valid(post_valid_r),
            .post_time (post_time_r),
            .wr_sel    (wr_sel_s),
            .wr_data   (wr_data),
            .weight    (weight[i*W_WIDTH +: W_WIDTH]),
            .upd       (upd[i])
        );
    end

endmodule

// File: tb/tb_stdp_synapse_array.sv
// Self-checking bench: directed table of spec scenarios with constant
// expectations, then randomized traffic; every edge is also compared against
// a spike-time reference model (absolute spike cycles, not timers).
module tb_stdp_synapse_array;

    localparam int N  = 8;
    localparam int WW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            learn_en;
    logic [N-1:0]    pre_spike;
    logic            post_spike;
    logic            wr_en;
    logic [2:0]      wr_idx;
    logic [WW-1:0]   wr_data;
    logic [N*WW-1:0] weight;
    logic [N-1:0]    upd;

    int total = 0;
    int bad   = 0;

    stdp_synapse_array dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .learn_en  (learn_en),
        .pre_spike (pre_spike),
        .post_spike(post_spike),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .weight    (weight),
        .upd       (upd)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (absolute spike times) ----------------
    int       mw[N];
    logic [N-1:0] mupd;
    int       last_pre[N];
    int       last_post;
    int       cyc = 0;

    function automatic int step_of(int a, int d);
        int sh;
        sh = d >> 2;
        if (sh >= WW) return 0;
        return a >> sh;
    endfunction

    function automatic void model_edge();
        int dp, dq, nw;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mw[i] = 100;
                last_pre[i] = -1;
            end
            last_post = -1;
            mupd = '0;
        end else begin
            dq = (last_post < 0) ? 0 : ((cyc - last_post - 1 > 255) ? 255 : cyc - last_post - 1);
            for (int i = 0; i < N; i++) begin
                dp = (last_pre[i] < 0) ? 0 : ((cyc - last_pre[i] - 1 > 255) ? 255 : cyc - last_pre[i] - 1);
                nw = mw[i];
                mupd[i] = 1'b0;
                if (wr_en && (int'(wr_idx) == i)) begin
                    nw = int'(wr_data);
                end else if (learn_en) begin
                    if (post_spike && !pre_spike[i] && last_pre[i] >= 0 && dp < 255) begin
                        nw = mw[i] + step_of(32, dp);
                        if (nw > 65535) nw = 65535;
                    end else if (pre_spike[i] && !post_spike && last_post >= 0 && dq < 255) begin
                        nw = mw[i] - step_of(32, dq);
                        if (nw < 0) nw = 0;
                    end
                    mupd[i] = (nw != mw[i]);
                end
                mw[i] = nw;
                if (pre_spike[i]) last_pre[i] = cyc;
            end
            if (post_spike) last_post = cyc;
        end
        cyc++;
    endfunction

    task automatic compare_model();
        logic [N*WW-1:0] ev;
        for (int i = 0; i < N; i++) ev[i*WW +: WW] = mw[i][WW-1:0];
        total++;
        if (weight !== ev) begin
            bad++;
            $display("FAIL model_weight cyc=%0d got=%h exp=%h", cyc, weight, ev);
        end
        total++;
        if (upd !== mupd) begin
            bad++;
            $display("FAIL model_upd cyc=%0d got=%b exp=%b", cyc, upd, mupd);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic         r;
        logic         l;
        logic [N-1:0] p;
        logic         po;
        logic         we;
        logic [2:0]   wi;
        logic [15:0]  wd;
        int           idle;
        int           chk;
        int           ew;
        logic [N-1:0] eu;
    } vec_t;

    vec_t tbl[$];

    function automatic void addv(logic r, logic l, logic [N-1:0] p, logic po,
                                 logic we, logic [2:0] wi, logic [15:0] wd,
                                 int idle, int chk, int ew, logic [N-1:0] eu);
        vec_t v;
        v.r = r; v.l = l; v.p = p; v.po = po; v.we = we; v.wi = wi; v.wd = wd;
        v.idle = idle; v.chk = chk; v.ew = ew; v.eu = eu;
        tbl.push_back(v);
    endfunction

    function automatic void add_rst();
        addv(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 16'd0, 0, 0, 100, 8'h00);
    endfunction

    initial begin
        rst_n = 1'b0; learn_en = 1'b1; pre_spike = '0; post_spike = 1'b0;
        wr_en = 1'b0; wr_idx = 3'd0; wr_data = 16'd0;

        // LTP: delta_t=4 -> +16, single pulse, others untouched
        add_rst();
        addv(1, 1, 8'h01, 0, 0, 0, 0,     0, 0, 100, 8'h00);
        addv(1, 1, 8'h00, 1, 0, 0, 0,     4, 0, 116, 8'h01);
        addv(1, 1, 8'h00, 0, 0, 0, 0,     0, 0, 116, 8'h00);
        addv(1, 1, 8'h00, 0, 0, 0, 0,     0, 1, 100, 8'h00);
        // LTD: delta_t=8 -> -8
        add_rst();
        addv(1, 1, 8'h00, 1, 0, 0, 0,     0, 3, 100, 8'h00);
        addv(1, 1, 8'h08, 0, 0, 0, 0,     8, 3, 92,  8'h08);
        // LTD: delta_t=0 -> -32
        add_rst();
        addv(1, 1, 8'h00, 1, 0, 0, 0,     0, 3, 100, 8'h00);
        addv(1, 1, 8'h08, 0, 0, 0, 0,     0, 3, 68,  8'h08);
        // upper clamp
        add_rst();
        addv(1, 1, 8'h00, 0, 1, 2, 65530, 0, 2, 65530, 8'h00);
        addv(1, 1, 8'h04, 0, 0, 0, 0,     0, 2, 65530, 8'h00);
        addv(1, 1, 8'h00, 1, 0, 0, 0,     0, 2, 65535, 8'h04);
        // lower clamp
        add_rst();
        addv(1, 1, 8'h00, 0, 1, 5, 10,    0, 5, 10,  8'h00);
        addv(1, 1, 8'h00, 1, 0, 0, 0,     0, 5, 10,  8'h00);
        addv(1, 1, 8'h20, 0, 0, 0, 0,     0, 5, 0,   8'h20);
        // post with no pre since reset
        add_rst();
        addv(1, 1, 8'h00, 1, 0, 0, 0,     0, 0, 100, 8'h00);
        // saturated timer outside window
        add_rst();
        addv(1, 1, 8'h01, 0, 0, 0, 0,     0, 0, 100, 8'h00);
        addv(1, 1, 8'h00, 1, 0, 0, 0,   299, 0, 100, 8'h00);
        // simultaneous pre/post: no change, pre timer restarted at 0
        add_rst();
        addv(1, 1, 8'h02, 1, 0, 0, 0,     0, 1, 100, 8'h00);
        addv(1, 1, 8'h00, 1, 0, 0, 0,     0, 1, 132, 8'h02);
        // learning disabled
        add_rst();
        addv(1, 0, 8'h01, 0, 0, 0, 0,     0, 0, 100, 8'h00);
        addv(1, 0, 8'h00, 1, 0, 0, 0,     2, 0, 100, 8'h00);
        // write beats LTP
        add_rst();
        addv(1, 1, 8'h01, 0, 0, 0, 0,     0, 0, 100, 8'h00);
        addv(1, 1, 8'h00, 1, 1, 0, 500,   0, 0, 500, 8'h00);
        // reset mid-run
        add_rst();
        addv(1, 1, 8'h03, 0, 0, 0, 0,     0, 0, 100, 8'h00);
        addv(1, 1, 8'h00, 1, 0, 0, 0,     0, 1, 132, 8'h03);
        add_rst();
        addv(1, 1, 8'h00, 1, 0, 0, 0,     0, 0, 100, 8'h00);

        foreach (tbl[k]) begin
            for (int j = 0; j < tbl[k].idle; j++) begin
                rst_n = 1'b1; learn_en = tbl[k].l; pre_spike = '0;
                post_spike = 1'b0; wr_en = 1'b0;
                tick();
            end
            rst_n = tbl[k].r; learn_en = tbl[k].l; pre_spike = tbl[k].p;
            post_spike = tbl[k].po; wr_en = tbl[k].we; wr_idx = tbl[k].wi;
            wr_data = tbl[k].wd;
            tick();
            total++;
            if (int'(weight[tbl[k].chk*WW +: WW]) != tbl[k].ew) begin
                bad++;
                $display("FAIL table_weight row=%0d syn=%0d got=%0d exp=%0d",
                         k, tbl[k].chk, weight[tbl[k].chk*WW +: WW], tbl[k].ew);
            end
            total++;
            if (upd !== tbl[k].eu) begin
                bad++;
                $display("FAIL table_upd row=%0d got=%b exp=%b", k, upd, tbl[k].eu);
            end
        end

        // ---------------- randomized traffic vs model ----------------
        for (int c = 0; c < 1500; c++) begin
            rst_n    = ($urandom_range(0, 299) != 0);
            learn_en = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < N; i++) pre_spike[i] = ($urandom_range(0, 11) == 0);
            post_spike = ($urandom_range(0, 9) == 0);
            wr_en  = ($urandom_range(0, 24) == 0);
            wr_idx = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0:       wr_data = 16'd5;
                1:       wr_data = 16'hFFF0;
                default: wr_data = 16'($urandom);
            endcase
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stdp_synapse_array.md
Name: stdp_synapse_array

Overview:
- Parametrised successor to the single-pair base-2 STDP synapse. Holds N_SYN plastic weights that share one postsynaptic neuron, each with its own presynaptic input.
- Applies pair-based base-2 STDP per synapse:
  - LTP: pre before post; weight increment is A_PLUS shifted right by (delta_t >> TAU_SHIFT).
  - LTD: post before pre; weight decrement is A_MINUS shifted right by (delta_t >> TAU_SHIFT).
- Adds over the previous generation: saturating time counters, "never spiked" tracking, configurable weight bounds, learning enable, and a host weight-write port.
- Sits between the spike encoder and the neuron core.

Parameters:
- N_SYN, 8, number of synapses (presynaptic channels)
- W_WIDTH, 16, weight width in bits
- T_WIDTH, 8, spike-timer width; timer saturates at 2^T_WIDTH-1
- A_PLUS, 32, LTP step at delta_t < 2^TAU_SHIFT
- A_MINUS, 32, LTD step at delta_t < 2^TAU_SHIFT
- TAU_SHIFT, 2, delta_t right shift (time-constant scaling)
- WINDOW, 255, learning window; update only if delta_t < WINDOW
- W_INIT, 100, weight value after reset
- W_MIN, 0, lower weight clamp
- W_MAX, 65535, upper weight clamp

Ports:
- clk, input, 1, clock
- rst_n, input, 1, synchronous active-low reset
- learn_en, input, 1, 1 = STDP updates enabled; timers run regardless
- pre_spike, input, N_SYN, presynaptic spike per synapse, one-cycle pulses
- post_spike, input, 1, postsynaptic spike
- wr_en, input, 1, host weight write strobe
- wr_idx, input, $clog2(N_SYN), synapse index for the write
- wr_data, input, W_WIDTH, write value, clamped to [W_MIN, W_MAX]
- weight, output, N_SYN*W_WIDTH, flattened weights; synapse i at bits [i*W_WIDTH +: W_WIDTH]
- upd, output, N_SYN, one-cycle pulse per synapse whose weight changed due to STDP

Behaviour:
- Reset (rst_n=0 at posedge):
  - all weights = W_INIT
  - all timers = 0
  - pre_valid[i] = 0, post_valid = 0
  - upd = 0
  - Reset mid-operation discards any in-flight update.
- Timers: one pre_time[i] per synapse plus one shared post_time.
  - On a spike: timer <= 0, valid <= 1.
  - Otherwise, if valid: timer increments and saturates at 2^T_WIDTH-1. No wrap.
- delta_t is the registered timer value at the edge that samples the opposite spike. Pre at edge k, post at edge k+d gives delta_t = d-1.
- LTP (synapse i): post_spike & ~pre_spike[i] & pre_valid[i] & pre_time[i] < WINDOW & learn_en.
  - dw = A_PLUS >> (pre_time[i] >> TAU_SHIFT)
  - weight = min(weight + dw, W_MAX), computed in W_WIDTH+1 bits
- LTD (synapse i): pre_spike[i] & ~post_spike & post_valid & post_time < WINDOW & learn_en.
  - dw = A_MINUS >> (post_time >> TAU_SHIFT)
  - weight = max(weight - dw, W_MIN), with no underflow
- Shift amount >= W_WIDTH gives dw = 0. An update with dw = 0 does not assert upd.
- Simultaneous pre_spike[i] and post_spike: no weight change for i; both timers reset.
- One post_spike evaluates LTP on all N_SYN synapses in the same cycle.
- Latency: the new weight and the upd pulse are visible one cycle after the sampling edge.
- Host write: wr_en has priority over STDP for synapse wr_idx in that cycle.
  - Timers still update.
  - upd is not asserted for a write.
  - wr_idx >= N_SYN is ignored.
- Weights are held whenever learn_en=0 and there is no write.

Decomposition:
- Package stdp_pkg:
  - weight_t and time_t typedefs
  - function stdp_dw(step, delta_t, tau_shift) implementing the shift with its zero-on-overflow rule
  - saturating add/sub clamp functions
- Sub-module stdp_synapse_cell: one weight register, its pre timer and pre_valid, LTP/LTD/clamp logic, and the write mux.
- Top level instantiates N_SYN cells and owns post_time and post_valid.

Test Plan:
- LTP: defaults, pre[0] at edge 0, post at edge 5 -> delta_t=4, dw=16, weight[0]=116, upd[0] pulses once; other weights stay 100.
- LTD: post at edge 0, pre[3] at edge 9 -> delta_t=8, dw=8, weight[3]=92; pre[3] at edge 1 instead -> weight[3]=68.
- Bounds: write 65530 to synapse 2, then pre[2] and post 1 cycle apart -> weight[2]=65535. Write 10 to synapse 5, then post and pre[5] 1 cycle apart -> weight[5]=0 (W_MIN).
- Validity/window/simultaneous, first sub-case: post with no prior pre since reset -> no change.
- Validity/window/simultaneous, second sub-case: pre, then post 300 cycles later -> timer saturated at 255 >= WINDOW, no change.
- Validity/window/simultaneous, third sub-case: pre[1] and post in the same cycle -> no change, both timers = 0.
- Control: learn_en=0 during a pre->post pair -> weights constant. wr_en and an LTP event on the same synapse -> weight = wr_data, upd=0.
- Reset mid-run: assert rst_n=0 for one cycle after several updates -> all weights 100, upd=0. Subsequent post without a new pre -> no change.
